// File: rtl/uart_loader.sv
// UART boot loader: 8N1 receiver feeding a length-prefixed image into word memory.
// Latency: a byte takes effect the cycle after its mid-stop sample; data is a combinational read.
// Backpressure: none; bytes arrive at line rate, and a missing byte is detected by idle timeout.
module uart_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_CLKS = 2700000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              cpu_enable,
  output logic [15:0]       words_loaded,
  output logic              frame_err
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int BYTES  = DATA_W / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS);
  localparam logic [16:0]       DEPTH_L   = 17'(DEPTH);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [1:0] LD_HDR0    = 2'd0;
  localparam logic [1:0] LD_HDR1    = 2'd1;
  localparam logic [1:0] LD_PAYLOAD = 2'd2;
  localparam logic [1:0] LD_DONE    = 2'd3;

  // Synchroniser resets to idle-high so a released reset never looks like a start bit.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  logic [1:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_vld_q, byte_vld_d;
  logic             stop_err;

  always_comb begin
    rx_state_d = rx_state_q;
    clk_cnt_d  = clk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_vld_d = 1'b0;
    stop_err   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      default: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) byte_vld_d = 1'b1;
          else           stop_err   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  logic [1:0]        ld_state_q, ld_state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       k_q, k_d;
  logic [BIDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0] word_q, word_d, word_full;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              frame_err_q, frame_err_d;
  logic              active, timeout, wr_en;

  assign active  = (ld_state_q == LD_HDR1) || (ld_state_q == LD_PAYLOAD);
  assign timeout = active && (idle_cnt_q == TO_LAST);

  // The received byte is still held in shift_q during the byte_vld_q cycle.
  always_comb begin
    word_full = word_q;
    word_full[{byte_idx_q, 3'b000} +: 8] = shift_q;
  end

  always_comb begin
    ld_state_d  = ld_state_q;
    n_d         = n_q;
    k_d         = k_q;
    byte_idx_d  = byte_idx_q;
    word_d      = word_q;
    wr_en       = 1'b0;
    idle_cnt_d  = (byte_vld_q || timeout || !active) ? '0 : idle_cnt_q + 1'b1;
    frame_err_d = frame_err_q | stop_err | timeout;
    if (byte_vld_q) begin
      if (ld_state_q == LD_HDR0 || ld_state_q == LD_DONE || timeout) begin
        ld_state_d = LD_HDR1;
        n_d        = {8'h00, shift_q};
        k_d        = '0;
        byte_idx_d = '0;
        word_d     = '0;
      end else if (ld_state_q == LD_HDR1) begin
        n_d        = {shift_q, n_q[7:0]};
        ld_state_d = ({shift_q, n_q[7:0]} == 16'd0) ? LD_DONE : LD_PAYLOAD;
      end else begin
        word_d = word_full;
        if (byte_idx_q == BIDX_LAST) begin
          byte_idx_d = '0;
          wr_en      = ({1'b0, k_q} < DEPTH_L);
          k_d        = (k_q == 16'hFFFF) ? k_q : k_q + 16'd1;
          if (k_q == n_q - 16'd1) ld_state_d = LD_DONE;
        end else begin
          byte_idx_d = byte_idx_q + 1'b1;
        end
      end
    end else if (timeout) begin
      ld_state_d = LD_HDR0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_state_q  <= LD_HDR0;
      n_q         <= '0;
      k_q         <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      idle_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      ld_state_q  <= ld_state_d;
      n_q         <= n_d;
      k_q         <= k_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      idle_cnt_q  <= idle_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Image memory is deliberately left out of reset so a crashed CPU can be reloaded over it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[ADDR_W'(k_q)] <= word_full;
  end

  assign data         = mem_q[address];
  assign cpu_enable   = (ld_state_q == LD_DONE);
  assign words_loaded = k_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: small bit period, 4-word memory, short idle timeout.
module tb_uart_loader;
  localparam int CPB = 8;
  localparam int TO  = 300;

  logic        clk;
  logic        reset;
  logic        uart_rx;
  logic [1:0]  address;
  logic [31:0] data;
  logic        cpu_enable;
  logic [15:0] words_loaded;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  uart_loader #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(32),
    .ADDR_W(2),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx(uart_rx),
    .address(address),
    .data(data),
    .cpu_enable(cpu_enable),
    .words_loaded(words_loaded),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, data, exp);
  endtask

  initial begin
    reset   = 1'b1;
    uart_rx = 1'b1;
    address = 2'd0;
    #1;
    check("rst_cpu_enable", {31'd0, cpu_enable}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Two-word image
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1);
    send_byte(8'h77, 1'b1);
    check("img2_cpu_en_before_last", {31'd0, cpu_enable}, 32'd0);
    check("img2_words_mid", {16'd0, words_loaded}, 32'd1);
    send_byte(8'h88, 1'b1);
    check("img2_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("img2_words", {16'd0, words_loaded}, 32'd2);
    check("img2_frame_err", {31'd0, frame_err}, 32'd0);
    check_mem("img2_mem0", 2'd0, 32'h44332211);
    check_mem("img2_mem1", 2'd1, 32'h88776655);

    // Empty image from DONE
    send_byte(8'h00, 1'b1);
    check("n0_cpu_en_drop", {31'd0, cpu_enable}, 32'd0);
    check("n0_words_zeroed", {16'd0, words_loaded}, 32'd0);
    send_byte(8'h00, 1'b1);
    check("n0_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("n0_words", {16'd0, words_loaded}, 32'd0);
    check_mem("n0_mem0", 2'd0, 32'h44332211);
    check_mem("n0_mem1", 2'd1, 32'h88776655);

    // Five words into a four-word memory
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 4; j++)
        send_byte(8'(16 * w + j), 1'b1);
    check("ovf_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("ovf_words", {16'd0, words_loaded}, 32'd5);
    check_mem("ovf_mem0_nowrap", 2'd0, 32'h03020100);
    check_mem("ovf_mem1", 2'd1, 32'h13121110);
    check_mem("ovf_mem2", 2'd2, 32'h23222120);
    check_mem("ovf_mem3", 2'd3, 32'h33323130);

    // Short image followed by silence
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hA0, 1'b1); send_byte(8'hA1, 1'b1);
    send_byte(8'hA2, 1'b1); send_byte(8'hA3, 1'b1);
    repeat (TO - 50) @(negedge clk);
    check("to_frame_err_early", {31'd0, frame_err}, 32'd0);
    repeat (100) @(negedge clk);
    check("to_frame_err", {31'd0, frame_err}, 32'd1);
    check("to_cpu_en", {31'd0, cpu_enable}, 32'd0);
    check("to_words", {16'd0, words_loaded}, 32'd1);
    check_mem("to_mem0", 2'd0, 32'hA3A2A1A0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hB0, 1'b1); send_byte(8'hB1, 1'b1);
    send_byte(8'hB2, 1'b1); send_byte(8'hB3, 1'b1);
    check("to_reload_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("to_reload_words", {16'd0, words_loaded}, 32'd1);
    check_mem("to_reload_mem0", 2'd0, 32'hB3B2B1B0);

    // Reset keeps memory, clears status asynchronously
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst2_cpu_en", {31'd0, cpu_enable}, 32'd0);
    check("rst2_words", {16'd0, words_loaded}, 32'd0);
    check("rst2_frame_err", {31'd0, frame_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_mem("rst2_mem1_kept", 2'd1, 32'h13121110);
    repeat (4) @(negedge clk);

    // Bad stop bit mid-payload
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h99, 1'b0);
    check("ferr_set", {31'd0, frame_err}, 32'd1);
    check("ferr_cpu_en_low", {31'd0, cpu_enable}, 32'd0);
    send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    check("ferr_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("ferr_words", {16'd0, words_loaded}, 32'd1);
    check_mem("ferr_mem0", 2'd0, 32'h44332211);

    // Reset in the middle of the third payload byte
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hC0, 1'b1); send_byte(8'hC1, 1'b1);
    uart_rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_frame_err_cleared", {31'd0, frame_err}, 32'd0);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1); send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1); send_byte(8'hDD, 1'b1);
    check("abort_cpu_en", {31'd0, cpu_enable}, 32'd1);
    check("abort_words", {16'd0, words_loaded}, 32'd1);
    check("abort_frame_err", {31'd0, frame_err}, 32'd0);
    check_mem("abort_mem0", 2'd0, 32'hDDCCBBAA);
    check_mem("abort_mem1", 2'd1, 32'h13121110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
UART_LOADER -- requirements
Module: uart_loader

Interface
REQ-001 SHALL expose parameters as name, default, meaning:
  CLKS_PER_BIT, 234, clk cycles per UART bit (27 MHz / 115200);
  DATA_W, 32, word width in bits, multiple of 8;
  ADDR_W, 8, word address width, DEPTH = 2^ADDR_W;
  TIMEOUT_CLKS, 2700000, idle cycles mid-load before framing abort.
REQ-002 SHALL have ports as name, direction, width, meaning:
  clk  in  1  sole clock, all state on posedge;
  reset  in  1  asynchronous, active-high;
  uart_rx  in  1  serial input, idle high, 8N1;
  address  in  ADDR_W  CPU fetch word address;
  data  out  DATA_W  word at address;
  cpu_enable  out  1  high when a complete image is loaded;
  words_loaded  out  16  words stored in current or last image;
  frame_err  out  1  sticky framing/timeout error.

Function
REQ-003 SHALL synchronise uart_rx through two flops before any use.
REQ-004 The receiver SHALL use states IDLE, START, DATA, STOP.
REQ-005 IDLE->START on a synchronised 1->0 transition; START checks the line at CLKS_PER_BIT/2 cycles, going to DATA if low and back to IDLE if high (glitch, no byte).
REQ-006 DATA SHALL sample 8 bits, LSB first, at CLKS_PER_BIT spacing from the mid-start point.
REQ-007 STOP SHALL sample one bit later:
  high -> one-cycle byte_valid with the byte;
  low -> discard byte, set frame_err, return IDLE.
REQ-008 The loader SHALL use states HDR0, HDR1, PAYLOAD, DONE.
REQ-009 Header bytes (HDR0, HDR1) form the 16-bit word count N, little-endian.
REQ-010 In PAYLOAD, each DATA_W/8 consecutive bytes SHALL form one word, first byte in bits [7:0].
REQ-011 Each completed word SHALL be written at word index k (0-based) in the same cycle its last byte is valid, then k increments.
REQ-012 Word indices k >= DEPTH SHALL not be written but SHALL still be counted; memory SHALL not wrap.
REQ-013 After word N-1 completes, the loader SHALL enter DONE and assert cpu_enable the next cycle.
REQ-014 N = 0 SHALL go HDR1 -> DONE directly, with words_loaded = 0.
REQ-015 words_loaded SHALL equal k, saturating at 16'hFFFF.
REQ-016 In DONE, a new valid byte SHALL be taken as HDR0 of a new image, drop cpu_enable in the same cycle it is captured, and zero k.
REQ-017 Memory contents SHALL persist across reloads until overwritten.
REQ-018 data SHALL be a combinational read of memory[address], with no latency.
REQ-019 In HDR1 or PAYLOAD, more than TIMEOUT_CLKS cycles without byte_valid SHALL set frame_err and return to HDR0; memory SHALL be kept and cpu_enable SHALL stay low.
REQ-020 A byte_valid arriving in the same cycle the timeout fires SHALL be treated as HDR0 of a new image.
REQ-021 A framing error SHALL not change loader state; the partial word SHALL continue with the next valid byte.

Reset
REQ-022 Asserting reset SHALL, without waiting for a clock edge:
  force receiver to IDLE and loader to HDR0;
  clear the byte assembler and all counters;
  set cpu_enable = 0, words_loaded = 0, frame_err = 0.
REQ-023 Memory SHALL not be cleared by reset.
REQ-024 Reset asserted mid-byte or mid-image SHALL abandon that byte/image; the first start bit after release SHALL be decoded as a fresh byte and taken as HDR0.

Verification
REQ-025 Send header 02 00 then bytes 11 22 33 44 55 66 77 88 ->
  mem[0] = 32'h44332211, mem[1] = 32'h88776655;
  cpu_enable = 1 one cycle after the last stop bit;
  words_loaded = 2.
REQ-026 Send header 00 00 -> cpu_enable = 1, words_loaded = 0, memory unchanged.
REQ-027 Send a byte with stop bit = 0 mid-payload -> frame_err = 1, the byte is ignored, and the load completes correctly once enough further bytes arrive.
REQ-028 Send header 03 00 and 4 payload bytes, then idle TIMEOUT_CLKS + 1 cycles ->
  frame_err = 1, cpu_enable = 0, mem[0] written;
  a subsequent 01 00 + 4 bytes loads mem[0] and sets cpu_enable.
REQ-029 With ADDR_W = 2, send N = 5 words ->
  mem[0..3] written, nothing at index 4;
  words_loaded = 5, cpu_enable = 1.
REQ-030 Assert reset during the third payload byte, then send 01 00 AA BB CC DD ->
  mem[0] = 32'hDDCCBBAA, cpu_enable = 1.
